// File: rtl/hilo_mdu_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit.
// The op encodings match the ones EX decodes; hl_wr_t is the {hi_we, lo_we, hi, lo} write bundle.
package hilo_mdu_pkg;

  localparam int unsigned Iter    = 32;
  localparam int unsigned MduOpWd = 2;
  localparam int unsigned HlDataW = 32;

  typedef logic [MduOpWd-1:0] mdu_op_t;

  localparam mdu_op_t MduOpMult  = 2'b00;
  localparam mdu_op_t MduOpMultu = 2'b01;
  localparam mdu_op_t MduOpDiv   = 2'b10;
  localparam mdu_op_t MduOpDivu  = 2'b11;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  typedef struct packed {
    logic               hi_we;
    logic               lo_we;
    logic [HlDataW-1:0] hi;
    logic [HlDataW-1:0] lo;
  } hl_wr_t;

  // Two's-complement magnitude; 0x80000000 maps to unsigned 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration on the 64-bit working register: shift-add for multiply,
// restoring trial-subtract for divide.
module mdu_iter_step (
  input  logic        is_div,
  input  logic [63:0] acc_i,
  input  logic [31:0] b_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic        borrow;
  logic [31:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i[63:32]} + {1'b0, b_i};
    rem_sh = acc_i[63:31];
    borrow = rem_sh < {1'b0, b_i};
    // When no borrow the true difference is below b_i, so 32 bits suffice.
    diff   = rem_sh[31:0] - b_i;
    if (!is_div) begin
      acc_o = acc_i[0] ? {sum, acc_i[31:1]} : {1'b0, acc_i[63:1]};
    end else begin
      acc_o = borrow ? {acc_i[62:0], 1'b0} : {diff, acc_i[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing a one-cycle HI/LO write.
// Works on operand magnitudes and applies the sign fix-up in DONE.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int unsigned ITER = Iter
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        hi_we_o,
  output logic        lo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     acc_q, acc_d, acc_step;
  logic [31:0]     opb_q, src1_q;
  logic            is_div_q, neg_res_q, neg_rem_q, div_zero_q;
  logic [31:0]     hi_q, lo_q;

  logic            accept, in_calc, in_done;
  logic            op_is_div, op_is_signed, s1_neg, s2_neg;
  logic [63:0]     prod;
  logic [31:0]     quo, rem;
  logic [31:0]     fix_hi, fix_lo;
  hl_wr_t          wr;

  assign op_is_div    = (op_i == MduOpDiv) || (op_i == MduOpDivu);
  assign op_is_signed = (op_i == MduOpMult) || (op_i == MduOpDiv);
  assign s1_neg       = op_is_signed & src1_i[31];
  assign s2_neg       = op_is_signed & src2_i[31];

  assign in_calc = (state_q == StCalc);
  assign in_done = (state_q == StDone);
  assign accept  = (state_q == StIdle) & start_i & ~flush_i;

  mdu_iter_step u_step (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .b_i    (opb_q),
    .acc_o  (acc_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCalc;
          cnt_d   = '0;
          // Multiplier (src2) or dividend (src1) starts in the low half.
          acc_d   = {32'd0, op_is_div ? mag32(src1_i, op_is_signed)
                                      : mag32(src2_i, op_is_signed)};
        end
      end
      StCalc: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_step;
          if (cnt_q == CntLast) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    prod = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quo  = acc_q[31:0];
    rem  = acc_q[63:32];
    if (!is_div_q) begin
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
    end else if (div_zero_q) begin
      fix_hi = src1_q;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_lo = neg_res_q ? (~quo + 32'd1) : quo;
      fix_hi = neg_rem_q ? (~rem + 32'd1) : rem;
    end
  end

  always_comb begin
    wr.hi_we = in_done & ~flush_i;
    wr.lo_we = in_done & ~flush_i;
    wr.hi    = wr.hi_we ? fix_hi : hi_q;
    wr.lo    = wr.lo_we ? fix_lo : lo_q;
  end

  assign hi_we_o = wr.hi_we;
  assign lo_we_o = wr.lo_we;
  assign hi_o    = wr.hi;
  assign lo_o    = wr.lo;
  assign stall_o = accept | (in_calc & ~flush_i);
  assign busy_o  = (state_q != StIdle);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      src1_q     <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (accept) begin
        opb_q      <= op_is_div ? mag32(src2_i, op_is_signed) : mag32(src1_i, op_is_signed);
        src1_q     <= src1_i;
        is_div_q   <= op_is_div;
        neg_res_q  <= s1_neg ^ s2_neg;
        neg_rem_q  <= s1_neg;
        div_zero_q <= op_is_div & (src2_i == 32'd0);
      end
      if (wr.hi_we) begin
        hi_q <= wr.hi;
        lo_q <= wr.lo;
      end
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: latency, results, sign fix-up, div-by-zero, flush and reset.
module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        hi_we_o;
  logic        lo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  always #5 clk = ~clk;

  hilo_mdu dut (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (start_i),
    .op_i    (op_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .hi_we_o (hi_we_o),
    .lo_we_o (lo_we_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drives a start at cycle T and returns at T+33 (+3) with stall/write activity tallied.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stall_hi, output int we_seen);
    op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
    #1;
    stall_hi = stall_o ? 1 : 0;
    we_seen  = 0;
    step();
    start_i = 1'b0;
    src1_i  = $urandom;
    src2_i  = $urandom;
    op_i    = 2'($urandom);
    for (int i = 0; i < 32; i++) begin
      #1;
      if (stall_o) stall_hi++;
      if (hi_we_o || lo_we_o) we_seen++;
      step();
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00;
    src1_i = 32'd0; src2_i = 32'd0;
    #3;
    checks++;
    if ({hi_we_o, lo_we_o, busy_o, stall_o, hi_o, lo_o} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {hi_we_o, lo_we_o, busy_o, stall_o, hi_o, lo_o});
    end
    #20;
    resetn = 1'b1;
    step();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy %b expected 0", busy_o);
    end
  endtask

  task automatic test_mult();
    int sh, we;
    step();
    issue(OpMult, 32'hFFFF_FFFD, 32'd5, sh, we);
    checks++;
    if (sh !== 33) begin
      errors++; $display("FAIL mult_stall_cycles: got %0d expected 33", sh);
    end
    checks++;
    if (we !== 0) begin
      errors++; $display("FAIL mult_early_write: got %0d expected 0", we);
    end
    checks++;
    if ({hi_we_o, lo_we_o, hi_o, lo_o} !== {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
      errors++;
      $display("FAIL mult_result: got %b %h %h expected 11 ffffffff fffffff1",
               {hi_we_o, lo_we_o}, hi_o, lo_o);
    end
    checks++;
    if ({stall_o, busy_o} !== 2'b01) begin
      errors++; $display("FAIL mult_done_flags: got %b expected 01", {stall_o, busy_o});
    end
    step();
    #1;
    checks++;
    if ({hi_we_o, lo_we_o, busy_o, hi_o, lo_o} !== {3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
      errors++;
      $display("FAIL mult_hold: got %b %h %h expected 000 ffffffff fffffff1",
               {hi_we_o, lo_we_o, busy_o}, hi_o, lo_o);
    end
    step();
    issue(OpMult, 32'h8000_0000, 32'h8000_0000, sh, we);
    checks++;
    if ({hi_we_o, hi_o, lo_o} !== {1'b1, 32'h4000_0000, 32'h0}) begin
      errors++;
      $display("FAIL mult_minint_sq: got %b %h %h expected 1 40000000 00000000",
               hi_we_o, hi_o, lo_o);
    end
  endtask

  task automatic test_back_to_back();
    int sh, we;
    step();
    issue(OpDivu, 32'd100, 32'd7, sh, we);
    checks++;
    if ({hi_we_o, lo_we_o, hi_o, lo_o} !== {2'b11, 32'd2, 32'd14}) begin
      errors++;
      $display("FAIL divu_100_7: got %b %h %h expected 11 00000002 0000000e",
               {hi_we_o, lo_we_o}, hi_o, lo_o);
    end
    checks++;
    if (sh !== 33) begin
      errors++; $display("FAIL divu_stall_cycles: got %0d expected 33", sh);
    end
    step();
    issue(OpDivu, 32'hFFFF_FFFF, 32'h10, sh, we);
    checks++;
    if ({hi_we_o, hi_o, lo_o} !== {1'b1, 32'hF, 32'h0FFF_FFFF}) begin
      errors++;
      $display("FAIL divu_back_to_back: got %b %h %h expected 1 0000000f 0fffffff",
               hi_we_o, hi_o, lo_o);
    end
  endtask

  task automatic test_div_signed();
    int sh, we;
    step();
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, sh, we);
    checks++;
    if ({hi_we_o, hi_o, lo_o} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      errors++;
      $display("FAIL div_m7_2: got %b %h %h expected 1 ffffffff fffffffd", hi_we_o, hi_o, lo_o);
    end
    step();
    issue(OpDiv, 32'd7, 32'hFFFF_FFFE, sh, we);
    checks++;
    if ({hi_we_o, hi_o, lo_o} !== {1'b1, 32'h1, 32'hFFFF_FFFD}) begin
      errors++;
      $display("FAIL div_7_m2: got %b %h %h expected 1 00000001 fffffffd", hi_we_o, hi_o, lo_o);
    end
    step();
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, sh, we);
    checks++;
    if ({hi_we_o, hi_o, lo_o} !== {1'b1, 32'h0, 32'h8000_0000}) begin
      errors++;
      $display("FAIL div_overflow: got %b %h %h expected 1 00000000 80000000", hi_we_o, hi_o, lo_o);
    end
  endtask

  task automatic test_div_zero();
    int sh, we;
    step();
    issue(OpDivu, 32'h1234_5678, 32'd0, sh, we);
    checks++;
    if ({hi_we_o, lo_we_o, hi_o, lo_o} !== {2'b11, 32'h1234_5678, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL divu_by_zero: got %b %h %h expected 11 12345678 ffffffff",
               {hi_we_o, lo_we_o}, hi_o, lo_o);
    end
    step();
    issue(OpDiv, 32'h1234_5678, 32'd0, sh, we);
    checks++;
    if ({hi_we_o, hi_o, lo_o} !== {1'b1, 32'h1234_5678, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL div_by_zero: got %b %h %h expected 1 12345678 ffffffff", hi_we_o, hi_o, lo_o);
    end
    checks++;
    if (sh !== 33) begin
      errors++; $display("FAIL div_zero_stall_cycles: got %0d expected 33", sh);
    end
  endtask

  task automatic test_flush();
    int we;
    int sh;
    step();
    op_i = OpMultu; src1_i = 32'd3; src2_i = 32'd4; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    start_i = 1'b1; src1_i = 32'd9; src2_i = 32'd9;
    #1;
    checks++;
    if ({busy_o, stall_o, hi_we_o} !== 3'b110) begin
      errors++; $display("FAIL flush_start_ignored: got %b expected 110", {busy_o, stall_o, hi_we_o});
    end
    step();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    flush_i = 1'b1;
    #1;
    checks++;
    if ({stall_o, hi_we_o, lo_we_o} !== 3'b000) begin
      errors++;
      $display("FAIL flush_calc_comb: got %b expected 000", {stall_o, hi_we_o, lo_we_o});
    end
    step();
    flush_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, stall_o} !== 2'b00) begin
      errors++; $display("FAIL flush_idle: got %b expected 00", {busy_o, stall_o});
    end
    we = 0;
    for (int i = 0; i < 30; i++) begin
      if (hi_we_o || lo_we_o) we++;
      step();
      #1;
    end
    checks++;
    if (we !== 0) begin
      errors++; $display("FAIL flush_no_write: got %0d expected 0", we);
    end
    checks++;
    if ({hi_o, lo_o} !== {32'h1234_5678, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL flush_hold: got %h %h expected 12345678 ffffffff", hi_o, lo_o);
    end
    start_i = 1'b1; flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL flush_start_idle_stall: got %b expected 0", stall_o);
    end
    step();
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_start_idle_busy: got %b expected 0", busy_o);
    end
    step();
    issue(OpMult, 32'd2, 32'd3, sh, we);
    flush_i = 1'b1;
    #1;
    checks++;
    if ({hi_we_o, lo_we_o, hi_o, lo_o} !== {2'b00, 32'h1234_5678, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL flush_done: got %b %h %h expected 00 12345678 ffffffff",
               {hi_we_o, lo_we_o}, hi_o, lo_o);
    end
    step();
    flush_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, hi_o} !== {1'b0, 32'h1234_5678}) begin
      errors++; $display("FAIL flush_done_after: got %b %h expected 0 12345678", busy_o, hi_o);
    end
  endtask

  task automatic test_reset_mid();
    int sh, we;
    step();
    op_i = OpDiv; src1_i = 32'd100; src2_i = 32'd3; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 19; i++) step();
    resetn = 1'b0;
    #1;
    checks++;
    if ({hi_we_o, lo_we_o, busy_o, stall_o, hi_o, lo_o} !== 68'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", {hi_we_o, lo_we_o, busy_o, stall_o, hi_o, lo_o});
    end
    step();
    resetn = 1'b1;
    we = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (hi_we_o || lo_we_o || busy_o) we++;
      step();
    end
    checks++;
    if (we !== 0) begin
      errors++; $display("FAIL reset_mid_no_write: got %0d expected 0", we);
    end
    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sh, we);
    checks++;
    if ({hi_we_o, lo_we_o, hi_o, lo_o} !== {2'b11, 32'hFFFF_FFFE, 32'h0000_0001}) begin
      errors++;
      $display("FAIL multu_max: got %b %h %h expected 11 fffffffe 00000001",
               {hi_we_o, lo_we_o}, hi_o, lo_o);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_signed();
    test_div_zero();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
